branch_ctrl: RTL and testbench
==============================

BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 2, number of cycles flush is held after a taken branch; legal range 1..7.
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port req_valid, input, 1, branch request present.
REQ-005 SHALL have port req_ready, output, 1, controller can accept a request.
REQ-006 SHALL have port funct3, input, 3, RV32I branch funct3: BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111.
REQ-007 SHALL have ports data1 and data2, input, 32 each, rs1 and rs2 operand values.
REQ-008 SHALL have ports pc and imm, input, 32 each, branch instruction PC and sign-extended B-immediate.
REQ-009 SHALL have port done_valid, output, 1, one-cycle pulse when a request is resolved.
REQ-010 SHALL have port taken, output, 1, resolution result; meaningful only while done_valid is high.
REQ-011 SHALL have port redirect_valid, output, 1, one-cycle fetch redirect pulse.
REQ-012 SHALL have port redirect_pc, output, 32, redirect target.
REQ-013 SHALL have port flush, output, 1, squash younger pipeline stages.
REQ-014 SHALL have port illegal, output, 1, one-cycle pulse for reserved funct3 (010, 011).
REQ-015 SHALL have port misalign, output, 1, one-cycle pulse when a taken target has target[1:0] != 0.
REQ-016 SHALL have ports br_count and taken_count, output, 32 each, statistics counters.

Function
REQ-017 SHALL implement FSM states IDLE, EVAL and FLUSH.
REQ-018 SHALL drive req_ready high only in IDLE; a handshake occurs when req_valid and req_ready are both high at a clock edge.
REQ-019 SHALL register funct3, data1, data2, pc and imm on handshake and move IDLE to EVAL.
REQ-020 SHALL, in EVAL, compare the registered operands: equality, signed less-than for BLT/BGE, unsigned less-than for BLTU/BGEU.
REQ-021 SHALL assert done_valid for exactly one cycle in EVAL, i.e. handshake at cycle t gives done_valid at t+1.
REQ-022 SHALL compute target = pc + imm modulo 2^32, so wrap-around is silent.
REQ-023 SHALL pulse illegal in EVAL for funct3 010 or 011, with taken=0, no redirect and no flush.
REQ-024 SHALL pulse misalign in EVAL for a taken branch whose target is misaligned, with taken=1, no redirect and no flush.
REQ-025 SHALL, for a taken, aligned branch, pulse redirect_valid with redirect_pc=target in EVAL (t+1), assert flush from t+1 through t+FLUSH_CYCLES inclusive, and return to IDLE so that req_ready is high at t+FLUSH_CYCLES+1.
REQ-026 SHALL, for a not-taken branch and for the illegal and misalign cases, go EVAL to IDLE directly so that req_ready is high at t+2.
REQ-027 SHALL use a 3-bit down-counter in FLUSH loaded with FLUSH_CYCLES-1 and leave FLUSH when the counter reaches 0.
REQ-028 SHALL increment br_count on every done_valid and increment taken_count when done_valid and taken are both high, both wrapping at 2^32; increments from one resolution land in the same cycle.
REQ-029 SHALL ignore req_valid outside IDLE, leaving inputs and state unchanged.
REQ-030 SHALL drive redirect_pc to 0 whenever redirect_valid is low.

Reset
REQ-031 SHALL, when rst is high at a clock edge, enter IDLE and clear all registers, counters and outputs to 0 except req_ready, which is 1 after reset.
REQ-032 SHALL give rst priority over every other event: reset during EVAL or FLUSH aborts the branch, drops flush on the next edge, produces no redirect and no count increment, and discards a simultaneous req_valid.

Structure
REQ-033 SHALL place the funct3 encodings, the FSM state enum and the flush counter width in a shared package, branch_pkg.
REQ-034 SHALL instantiate one combinational sub-module, branch_cmp (inputs data1, data2, unsigned-select; outputs eq, lt), as the sole comparison logic.

Verification
REQ-035 SHALL test BEQ with data1=data2=5, pc=0x100, imm=0x20, handshake at t -> done_valid=1, taken=1, redirect_pc=0x120 at t+1; flush at t+1..t+2; req_ready high at t+3.
REQ-036 SHALL test BLT data1=0xFFFFFFFF, data2=1 -> taken=1; BLTU with the same operands -> taken=0 and req_ready high at t+2.
REQ-037 SHALL test funct3=010 -> illegal pulse at t+1, no flush, br_count +1, taken_count unchanged.
REQ-038 SHALL test BNE data1=1, data2=2, pc=0x100, imm=0x2 -> misalign=1, redirect_valid=0, flush=0.
REQ-039 SHALL test pc=0xFFFFFFF0, imm=0x20, BGEU 3>=3 -> redirect_pc=0x00000010 (wrap).
REQ-040 SHALL test rst asserted at the first FLUSH cycle -> flush=0 and req_ready=1 after the edge, counters=0; then 10 back-to-back requests held on req_valid -> br_count=10 with none lost or duplicated.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolution controller.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package branch_pkg;

    // RV32I conditional-branch funct3 encodings; 010/011 are reserved.
    typedef enum logic [2:0] {
        F3_BEQ  = 3'b000,
        F3_BNE  = 3'b001,
        F3_RSV2 = 3'b010,
        F3_RSV3 = 3'b011,
        F3_BLT  = 3'b100,
        F3_BGE  = 3'b101,
        F3_BLTU = 3'b110,
        F3_BGEU = 3'b111
    } funct3_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EVAL  = 2'd1,
        FLUSH = 2'd2
    } state_e;

    // Wide enough for the largest legal FLUSH_CYCLES-1 (6).
    localparam int FLUSH_CNT_W = 3;

    function automatic logic isReserved(input logic [2:0] f3);
        return (f3[2:1] == 2'b01);
    endfunction

    // BLTU/BGEU are the only encodings with bit 1 set among legal branches.
    function automatic logic usesUnsigned(input logic [2:0] f3);
        return f3[1];
    endfunction

endpackage

// File: rtl/branch_ctrl_if.sv
// Request/result bundle between the issue stage and the branch controller.
// Latency: n/a (wires only).
// Backpressure: request side is valid/ready; result side is pulse-only, no ready.
// Ports: req_valid/req_ready/funct3/data1/data2/pc/imm toward the controller;
//        done_valid/taken/redirect_*/flush/illegal/misalign/counters back.
interface branch_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  funct3;
    logic [31:0] data1;
    logic [31:0] data2;
    logic [31:0] pc;
    logic [31:0] imm;
    logic        done_valid;
    logic        taken;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush;
    logic        illegal;
    logic        misalign;
    logic [31:0] br_count;
    logic [31:0] taken_count;

    modport master (
        output req_valid, funct3, data1, data2, pc, imm,
        input  req_ready, done_valid, taken, redirect_valid, redirect_pc,
               flush, illegal, misalign, br_count, taken_count
    );

    modport slave (
        input  req_valid, funct3, data1, data2, pc, imm,
        output req_ready, done_valid, taken, redirect_valid, redirect_pc,
               flush, illegal, misalign, br_count, taken_count
    );
endinterface

// File: rtl/branch_cmp.sv
// Operand comparator shared by all branch conditions.
// Latency: combinational.
// Backpressure: none.
// Ports: data1/data2 operands, isUnsigned selects unsigned ordering; eq, lt results.
module branch_cmp (
    input  logic [31:0] data1,
    input  logic [31:0] data2,
    input  logic        isUnsigned,
    output logic        eq,
    output logic        lt
);
    assign eq = (data1 == data2);
    assign lt = isUnsigned ? (data1 < data2)
                           : ($signed(data1) < $signed(data2));
endmodule

// File: rtl/branch_ctrl.sv
// Resolves one RV32I conditional branch at a time and drives fetch redirect/flush.
// Latency: result one cycle after handshake; busy FLUSH_CYCLES cycles on a taken branch, else one.
// Backpressure: req_ready high only in IDLE; requests outside IDLE are ignored.
// Ports: clk, rst (sync, active-high), bus (slave side of branch_ctrl_if).
module branch_ctrl
    import branch_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic         clk,
    input  logic         rst,
    branch_ctrl_if.slave bus
);
    localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

    state_e                 state, stateD;
    logic [FLUSH_CNT_W-1:0] flushCnt, flushCntD;
    logic [2:0]             funct3Q;
    logic [31:0]            data1Q, data2Q, pcQ, immQ;
    logic [31:0]            brCount, takenCount;

    logic        eq, lt, condTrue, illegalNow, misalignNow;
    logic [31:0] target;
    logic        reqReady, doneValid, takenOut, redirectValid;
    logic        flushOut, illegalOut, misalignOut;

    branch_cmp u_cmp (
        .data1      (data1Q),
        .data2      (data2Q),
        .isUnsigned (usesUnsigned(funct3Q)),
        .eq         (eq),
        .lt         (lt)
    );

    // Target wraps silently at 2^32.
    assign target     = pcQ + immQ;
    assign illegalNow = isReserved(funct3Q);

    always_comb begin
        condTrue = 1'b0;
        case (funct3_e'(funct3Q))
            F3_BEQ:           condTrue = eq;
            F3_BNE:           condTrue = !eq;
            F3_BLT, F3_BLTU:  condTrue = lt;
            F3_BGE, F3_BGEU:  condTrue = !lt;
            default:          condTrue = 1'b0;
        endcase
    end

    assign misalignNow = condTrue && (target[1:0] != 2'b00);

    always_comb begin
        stateD        = state;
        flushCntD     = flushCnt;
        reqReady      = 1'b0;
        doneValid     = 1'b0;
        takenOut      = 1'b0;
        redirectValid = 1'b0;
        flushOut      = 1'b0;
        illegalOut    = 1'b0;
        misalignOut   = 1'b0;
        case (state)
            IDLE: begin
                reqReady = 1'b1;
                if (bus.req_valid) stateD = EVAL;
            end
            EVAL: begin
                doneValid   = 1'b1;
                takenOut    = condTrue;
                illegalOut  = illegalNow;
                misalignOut = misalignNow;
                stateD      = IDLE;
                if (condTrue && !misalignNow) begin
                    redirectValid = 1'b1;
                    // EVAL itself is the first flush cycle; FLUSH covers the rest.
                    flushOut = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        stateD    = FLUSH;
                        flushCntD = FLUSH_LOAD;
                    end
                end
            end
            FLUSH: begin
                flushOut  = 1'b1;
                flushCntD = flushCnt - 1'b1;
                // Leaving as the counter steps down to zero.
                if (flushCnt <= FLUSH_CNT_W'(1)) stateD = IDLE;
            end
            default: stateD = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            flushCnt   <= '0;
            funct3Q    <= '0;
            data1Q     <= '0;
            data2Q     <= '0;
            pcQ        <= '0;
            immQ       <= '0;
            brCount    <= '0;
            takenCount <= '0;
        end else begin
            state    <= stateD;
            flushCnt <= flushCntD;
            if (reqReady && bus.req_valid) begin
                funct3Q <= bus.funct3;
                data1Q  <= bus.data1;
                data2Q  <= bus.data2;
                pcQ     <= bus.pc;
                immQ    <= bus.imm;
            end
            if (doneValid) brCount <= brCount + 32'd1;
            if (doneValid && takenOut) takenCount <= takenCount + 32'd1;
        end
    end

    assign bus.req_ready      = reqReady;
    assign bus.done_valid     = doneValid;
    assign bus.taken          = takenOut;
    assign bus.redirect_valid = redirectValid;
    assign bus.redirect_pc    = redirectValid ? target : 32'd0;
    assign bus.flush          = flushOut;
    assign bus.illegal        = illegalOut;
    assign bus.misalign       = misalignOut;
    assign bus.br_count       = brCount;
    assign bus.taken_count    = takenCount;
endmodule

// File: tb/tb_branch_ctrl.sv
// Directed plus randomized checks of branch_ctrl against a behavioural model.
// Latency: n/a.
// Backpressure: n/a.
module tb_branch_ctrl;
    localparam int FC = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    branch_ctrl_if bus();

    branch_ctrl #(.FLUSH_CYCLES(FC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int expBr  = 0;
    int expTk  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Architectural meaning of a branch, using wide arithmetic for ordering.
    task automatic refModel(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] p, input logic [31:0] i,
                            output bit ill, output bit tk, output bit mis, output bit redir,
                            output logic [31:0] tgt);
        longint sa, sb, ua, ub, sum;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = longint'(a);
        ub  = longint'(b);
        sum = (longint'(p) + longint'(i)) % (longint'(1) << 32);
        tgt = 32'(sum);
        ill = 0;
        tk  = 0;
        case (f3)
            3'd0: tk = (a == b);
            3'd1: tk = (a != b);
            3'd4: tk = (sa - sb) < 0;
            3'd5: tk = (sa - sb) >= 0;
            3'd6: tk = (ua - ub) < 0;
            3'd7: tk = (ua - ub) >= 0;
            default: ill = 1;
        endcase
        mis   = tk && ((sum % 4) != 0);
        redir = tk && !mis;
    endtask

    // Issue one request from IDLE and follow it until the controller is ready again.
    task automatic doReq(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] p, input logic [31:0] i);
        bit ill, tk, mis, redir;
        logic [31:0] tgt;
        int expLat, lat;
        refModel(f3, a, b, p, i, ill, tk, mis, redir, tgt);
        expLat = redir ? FC + 1 : 2;
        check({tag, ".ready0"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.funct3    = f3;
        bus.data1     = a;
        bus.data2     = b;
        bus.pc        = p;
        bus.imm       = i;
        step();
        // Scramble the inputs and keep valid wiggling: none of it may be taken in.
        bus.req_valid = 1'($urandom);
        bus.funct3    = 3'($urandom);
        bus.data1     = $urandom;
        bus.data2     = $urandom;
        bus.pc        = $urandom;
        bus.imm       = $urandom;
        check({tag, ".done"},     32'(bus.done_valid),     32'd1);
        check({tag, ".taken"},    32'(bus.taken),          32'(tk));
        check({tag, ".illegal"},  32'(bus.illegal),        32'(ill));
        check({tag, ".misalign"}, 32'(bus.misalign),       32'(mis));
        check({tag, ".redirV"},   32'(bus.redirect_valid), 32'(redir));
        check({tag, ".redirPc"},  bus.redirect_pc,         redir ? tgt : 32'd0);
        check({tag, ".flush1"},   32'(bus.flush),          32'(redir));
        check({tag, ".busy"},     32'(bus.req_ready),      32'd0);
        expBr++;
        if (tk) expTk++;
        lat = 0;
        for (int k = 2; k <= 12; k++) begin
            step();
            check({tag, ".flushK"}, 32'(bus.flush),      32'(redir && (k <= FC)));
            check({tag, ".doneK"},  32'(bus.done_valid), 32'd0);
            check({tag, ".readyK"}, 32'(bus.req_ready),  32'(k == expLat));
            if (bus.req_ready) begin
                lat = k;
                bus.req_valid = 1'b0;
                break;
            end
            bus.req_valid = 1'($urandom);
            bus.data1     = $urandom;
        end
        check({tag, ".latency"}, 32'(lat), 32'(expLat));
        check({tag, ".brCnt"},   bus.br_count,    32'(expBr));
        check({tag, ".tkCnt"},   bus.taken_count, 32'(expTk));
    endtask

    initial begin
        logic [2:0]  f3;
        logic [31:0] a, b, p, i;
        int hs, dones;

        bus.req_valid = 1'b0;
        bus.funct3    = '0;
        bus.data1     = '0;
        bus.data2     = '0;
        bus.pc        = '0;
        bus.imm       = '0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;

        check("rst.ready",   32'(bus.req_ready),      32'd1);
        check("rst.done",    32'(bus.done_valid),     32'd0);
        check("rst.flush",   32'(bus.flush),          32'd0);
        check("rst.redirV",  32'(bus.redirect_valid), 32'd0);
        check("rst.redirPc", bus.redirect_pc,         32'd0);
        check("rst.brCnt",   bus.br_count,            32'd0);
        check("rst.tkCnt",   bus.taken_count,         32'd0);

        doReq("beq",      3'b000, 32'd5, 32'd5, 32'h100, 32'h20);
        doReq("blt",      3'b100, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40);
        doReq("bltu",     3'b110, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40);
        doReq("illegal",  3'b010, 32'd7, 32'd7, 32'h300, 32'h8);
        doReq("illegal3", 3'b011, 32'd1, 32'd2, 32'h300, 32'h8);
        doReq("misalign", 3'b001, 32'd1, 32'd2, 32'h100, 32'h2);
        doReq("wrap",     3'b111, 32'd3, 32'd3, 32'hFFFF_FFF0, 32'h20);
        doReq("bge",      3'b101, 32'h8000_0000, 32'd0, 32'h40, 32'hFFFF_FFF0);

        for (int n = 0; n < 150; n++) begin
            f3 = 3'($urandom);
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
            if ($urandom_range(0, 1) == 1) begin
                a = 32'($urandom_range(0, 3)) - 32'd1;
                b = 32'($urandom_range(0, 3)) - 32'd1;
            end
            p = $urandom;
            i = $urandom;
            if ($urandom_range(0, 2) != 0) begin
                p[1:0] = 2'b00;
                i[1:0] = 2'b00;
            end
            doReq("rand", f3, a, b, p, i);
            for (int g = $urandom_range(0, 2); g > 0; g--) step();
        end

        // Reset in the first FLUSH cycle, with a request offered at the same edge.
        bus.req_valid = 1'b1;
        bus.funct3    = 3'b000;
        bus.data1     = 32'd5;
        bus.data2     = 32'd5;
        bus.pc        = 32'h100;
        bus.imm       = 32'h20;
        step();
        bus.req_valid = 1'b0;
        step();
        check("rstFl.preFlush", 32'(bus.flush), 32'd1);
        rst = 1'b1;
        bus.req_valid = 1'b1;
        step();
        rst = 1'b0;
        bus.req_valid = 1'b0;
        expBr = 0;
        expTk = 0;
        check("rstFl.flush",  32'(bus.flush),          32'd0);
        check("rstFl.ready",  32'(bus.req_ready),      32'd1);
        check("rstFl.redirV", 32'(bus.redirect_valid), 32'd0);
        check("rstFl.brCnt",  bus.br_count,            32'd0);
        check("rstFl.tkCnt",  bus.taken_count,         32'd0);
        step();
        check("rstFl.noDone", 32'(bus.done_valid), 32'd0);

        // Ten back-to-back not-taken requests with req_valid held high throughout.
        hs = 0;
        dones = 0;
        bus.funct3 = 3'b001;
        for (int c = 0; c < 60; c++) begin
            if (bus.req_ready && hs < 10) begin
                bus.req_valid = 1'b1;
                bus.data1     = 32'(c);
                bus.data2     = 32'(c);
                hs++;
            end else if (hs >= 10 && !bus.req_ready) begin
                bus.req_valid = 1'b0;
            end
            step();
            if (bus.done_valid) dones++;
        end
        bus.req_valid = 1'b0;
        check("b2b.dones", 32'(dones),       32'd10);
        check("b2b.brCnt", bus.br_count,     32'd10);
        check("b2b.tkCnt", bus.taken_count,  32'd0);
        check("b2b.ready", 32'(bus.req_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
